// File: rtl/axis_i2s_param.sv
// AXI-Stream <-> I2S controller for the Pmod I2S2 with both codecs in slave mode.
// A single free-running frame counter derives lrck/sclk; TX is double-buffered, RX is sign-extended.
module axis_i2s_param #(
    parameter int DATA_WIDTH    = 24,
    parameter int SLOT_BITS     = 32,
    parameter int SCLK_DIV_LOG2 = 3,
    parameter bit STEREO        = 1'b1
) (
    input  logic        axis_clk,
    input  logic        axis_reset,
    input  logic [31:0] tx_axis_s_data,
    input  logic        tx_axis_s_valid,
    output logic        tx_axis_s_ready,
    input  logic        tx_axis_s_last,
    output logic [31:0] rx_axis_m_data,
    output logic        rx_axis_m_valid,
    input  logic        rx_axis_m_ready,
    output logic        rx_axis_m_last,
    output logic        tx_mclk,
    output logic        rx_mclk,
    output logic        tx_lrck,
    output logic        rx_lrck,
    output logic        tx_sclk,
    output logic        rx_sclk,
    output logic        tx_sdout,
    input  logic        rx_sdin,
    output logic        tx_underrun,
    output logic        rx_overrun
);

    localparam int K         = SCLK_DIV_LOG2;
    localparam int FRAME_LEN = 2 * SLOT_BITS * (2 ** K);
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int BW        = CW - 1 - K;
    localparam int DW        = DATA_WIDTH;
    localparam logic [BW-1:0] DW_B      = BW'(DW);
    localparam logic [K-1:0]  SAMPLE_PH = K'((2 ** (K - 1)) - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);

    function automatic logic [31:0] sext(input logic [DW-1:0] v);
        sext = {{(32 - DW){v[DW-1]}}, v};
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] b_s, nx_b_s;
    logic          lr_s, nx_lr_s;
    logic [DW-1:0] tx_word_s, tx_shift_s, in_data_s;
    logic          tx_bit_s, sdout_q, sdout_d;
    logic [2:0]    sync_q;
    logic [DW-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic          full_q, full_d, pos_q, pos_d, accept_s;
    logic [DW-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DW-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic          underrun_q, underrun_d, overrun_q, overrun_d;
    logic          rx_valid_q, rx_valid_d, rx_last_q, rx_last_d;
    logic [31:0]   rx_data_q, rx_data_d;
    logic [DW-1:0] cap_r_q, cap_r_d;
    logic          unused_s;

    assign in_data_s = tx_axis_s_data[DW-1:0];
    assign unused_s  = ^tx_axis_s_data;
    assign accept_s  = tx_axis_s_valid & ~full_q;

    // Frame counter and next serial TX bit; tx_sdout only moves as sclk falls (low bits roll to 0).
    always_comb begin
        cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        nx_b_s     = cnt_d[CW-2:K];
        nx_lr_s    = cnt_d[CW-1];
        tx_word_s  = nx_lr_s ? tx_r_q : tx_l_q;
        tx_shift_s = tx_word_s >> (DW_B - nx_b_s);
        if ((nx_b_s != '0) && (nx_b_s <= DW_B)) begin
            tx_bit_s = tx_shift_s[0];
        end else begin
            tx_bit_s = 1'b0;
        end
        if (cnt_d[K-1:0] == '0) begin
            sdout_d = tx_bit_s;
        end else begin
            sdout_d = sdout_q;
        end
    end

    // RX shift registers, sampled the cycle before sclk rises.
    always_comb begin
        b_s    = cnt_q[CW-2:K];
        lr_s   = cnt_q[CW-1];
        rx_l_d = rx_l_q;
        rx_r_d = rx_r_q;
        if ((cnt_q[K-1:0] == SAMPLE_PH) && (b_s != '0) && (b_s <= DW_B)) begin
            if (lr_s) begin
                rx_r_d = {rx_r_q[DW-2:0], sync_q[2]};
            end else begin
                rx_l_d = {rx_l_q[DW-2:0], sync_q[2]};
            end
        end else begin
            rx_l_d = rx_l_q;
            rx_r_d = rx_r_q;
        end
    end

    // TX holding buffer fill and frame-start load (the load sees full_q from before this cycle).
    always_comb begin
        full_d     = full_q;
        pos_d      = pos_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        underrun_d = 1'b0;
        if (cnt_q == '0) begin
            if (full_q) begin
                tx_l_d = buf_l_q;
                tx_r_d = buf_r_q;
                full_d = 1'b0;
            end else begin
                tx_l_d     = '0;
                tx_r_d     = '0;
                underrun_d = 1'b1;
            end
        end else begin
            tx_l_d = tx_l_q;
        end
        if (accept_s) begin
            if (STEREO == 1'b0) begin
                buf_l_d = in_data_s;
                buf_r_d = in_data_s;
                full_d  = 1'b1;
            end else if (pos_q == 1'b0) begin
                buf_l_d = in_data_s;
                if (tx_axis_s_last) begin
                    buf_r_d = in_data_s;
                    full_d  = 1'b1;
                end else begin
                    pos_d = 1'b1;
                end
            end else begin
                buf_r_d = in_data_s;
                full_d  = 1'b1;
                pos_d   = 1'b0;
            end
        end else begin
            pos_d = pos_q;
        end
    end

    // RX output beats and end-of-frame capture; a frame arriving while a beat is held is dropped.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_last_d  = rx_last_q;
        rx_data_d  = rx_data_q;
        cap_r_d    = cap_r_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_axis_m_ready) begin
            rx_last_d = ~rx_last_q;
            if ((STEREO == 1'b1) && !rx_last_q) begin
                rx_data_d = sext(cap_r_q);
            end else begin
                rx_valid_d = 1'b0;
            end
        end else begin
            rx_last_d = rx_last_q;
        end
        if (cnt_q == LAST_CNT) begin
            if (!rx_valid_q) begin
                rx_data_d  = sext(rx_l_q);
                cap_r_d    = rx_r_q;
                rx_valid_d = 1'b1;
                rx_last_d  = (STEREO == 1'b0);
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            cnt_q      <= '0;
            sdout_q    <= 1'b0;
            sync_q     <= 3'b000;
            rx_l_q     <= '0;
            rx_r_q     <= '0;
            full_q     <= 1'b0;
            pos_q      <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            tx_l_q     <= '0;
            tx_r_q     <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            rx_data_q  <= 32'd0;
            cap_r_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sdout_q    <= sdout_d;
            sync_q     <= {sync_q[1:0], rx_sdin};
            rx_l_q     <= rx_l_d;
            rx_r_q     <= rx_r_d;
            full_q     <= full_d;
            pos_q      <= pos_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            rx_valid_q <= rx_valid_d;
            rx_last_q  <= rx_last_d;
            rx_data_q  <= rx_data_d;
            cap_r_q    <= cap_r_d;
        end
    end

    assign tx_axis_s_ready = ~full_q & ~axis_reset;
    assign rx_axis_m_data  = rx_data_q;
    assign rx_axis_m_valid = rx_valid_q;
    assign rx_axis_m_last  = rx_last_q;
    assign tx_mclk         = axis_clk;
    assign rx_mclk         = axis_clk;
    assign tx_lrck         = cnt_q[CW-1];
    assign rx_lrck         = cnt_q[CW-1];
    assign tx_sclk         = cnt_q[K-1];
    assign rx_sclk         = cnt_q[K-1];
    assign tx_sdout        = sdout_q;
    assign tx_underrun     = underrun_q;
    assign rx_overrun      = overrun_q;

endmodule
